pmem_slave: RTL and testbench
=============================

Name: pmem_slave

Overview:
- Memory responder: the target end of the core's memory-access interface.
- Accepts one read or write request at a time on a valid/ready request channel and waits a programmable latency.
- Performs the access through DPI-C `pmem_read` / `pmem_write` against the simulator's physical memory, then returns a response on a valid/ready response channel.
- Instantiated behind the fetch and load/store initiators to model non-zero memory latency.

Parameters:
- LAT, 2: wait cycles between request acceptance and memory access; legal range 0..15.
- AW, 32: address width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  slave can accept a request
- req_wen  in  1  1 = write, 0 = read
- req_addr  in  AW  byte address; must be word-aligned
- req_wdata  in  32  write data
- req_wstrb  in  4  byte-enable mask; bit i enables byte i
- resp_valid  out  1  response present
- resp_ready  in  1  master accepts the response
- resp_rdata  out  32  read data; 0 for writes and errors
- resp_err  out  1  misaligned-address error

Behaviour:
- Reset (async, immediate):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
  - Reset mid-transaction discards the request; if asserted before the access edge, no DPI call is made.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch wen/addr/wdata/wstrb and load counter=LAT.
  - Next state is WAIT if LAT>0, else ACCESS performed on this same edge and next state is RESP.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - On the edge where counter==1: perform ACCESS, go to RESP.
- ACCESS, performed once per transaction:
  - If addr[1:0]!=0: no DPI call, err=1, rdata=0.
  - Else read: rdata=pmem_read(addr,4), err=0.
  - Else write: pmem_write(addr,wdata,wstrb), rdata=0, err=0.
  - wstrb=0 still calls pmem_write; memory contents are left unchanged.
  - The access result is registered; outputs change only at clock edges.
- RESP:
  - resp_valid=1; rdata/err stay stable while resp_ready=0.
  - On resp_valid&&resp_ready: resp_valid=0 and state=IDLE next cycle.
- Latency: resp_valid first high LAT+1 cycles after the accepting edge. Minimum transaction period is LAT+2 cycles.
- Back-to-back: a request held on req_valid during WAIT/RESP is not accepted. It is accepted in the first IDLE cycle.
- Master request fields may change after acceptance without effect.
- Only one outstanding transaction; no reordering.

Decomposition:
- Shared package pmem_pkg:
  - state enum {IDLE, WAIT, RESP}
  - WORD_BYTES=4
  - DPI import declarations for pmem_read(int addr, int len) and pmem_write(int addr, int data, byte mask), shared with the fetch unit
- No sub-module: FSM, counter and request registers live in a single module.
- The counter width is $clog2(LAT+1), minimum 1.

Test Plan:
- Read, LAT=2:
  - Preload 0x80000000=0x00000413.
  - Request rd addr 0x80000000 at cycle 0, resp_ready=1.
  - resp_valid high at cycle 3, rdata=0x00000413, err=0, req_ready high at cycle 4.
- Byte-masked write:
  - Preload 0x80000010=0x11223344.
  - Write wdata=0xAABBCCDD, wstrb=4'b0101; resp err=0, rdata=0.
  - Subsequent read returns 0x11BB33DD.
- Response backpressure:
  - resp_ready=0 for 5 cycles after resp_valid.
  - resp_valid and rdata stay stable for those cycles; req_ready stays 0; a second req_valid is not accepted until the cycle after the handshake.
- Misaligned address:
  - Read at 0x80000002 → resp_err=1, rdata=0, no DPI call (count calls = 0).
  - Write at 0x80000001 → memory unchanged.
- Reset mid-operation:
  - Write to 0x80000020 (old value 0xDEADBEEF); assert rst during WAIT.
  - Outputs return to reset values immediately; memory still reads 0xDEADBEEF; the next request completes normally.
- LAT=0 build:
  - Read accepted at cycle 0 → resp_valid at cycle 1.
  - Back-to-back reads with resp_ready=1 complete every 2 cycles.

Source files
------------

// File: rtl/pmem_pkg.sv
// Shared memory-access definitions: responder states, word size and the
// physical-memory access routines used by the fetch and load/store paths.
package pmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int WORD_BYTES = 4;

  // Behavioural physical memory keyed by word address, plus an access count.
  int unsigned pmem_mem [int unsigned];
  int unsigned pmem_calls;

  function automatic int pmem_read(input int addr, input int len);
    int unsigned a;
    int unsigned v;
    a = int'(addr) & ~32'h3;
    pmem_calls++;
    v = pmem_mem.exists(a) ? pmem_mem[a] : 32'h0;
    if (len < WORD_BYTES)
      v = v & ((32'h1 << (8 * len)) - 32'h1);
    return int'(v);
  endfunction

  function automatic void pmem_write(input int addr, input int data, input byte mask);
    int unsigned a;
    int unsigned w;
    a = int'(addr) & ~32'h3;
    pmem_calls++;
    w = pmem_mem.exists(a) ? pmem_mem[a] : 32'h0;
    for (int i = 0; i < WORD_BYTES; i++)
      if (mask[i]) w[8*i +: 8] = data[8*i +: 8];
    pmem_mem[a] = w;
  endfunction

endpackage

// File: rtl/pmem_slave_if.sv
// Request/response channel between a memory initiator and pmem_slave.
interface pmem_slave_if #(parameter int AW = 32);
  logic          req_valid;
  logic          req_ready;
  logic          req_wen;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [3:0]    req_wstrb;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/pmem_slave.sv
// Memory responder: accepts one request, waits LAT cycles, accesses physical
// memory once, then holds the registered response until the master takes it.
module pmem_slave
  import pmem_pkg::*;
#(
  parameter int LAT = 2,
  parameter int AW  = 32
) (
  input logic         clk,
  input logic         rst,
  pmem_slave_if.slave bus
);

  localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam logic [CW-1:0] LAT_C = CW'(LAT);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic          wen_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic          accept, do_acc;
  logic          a_wen;
  logic [AW-1:0] a_addr;
  logic [31:0]   a_wdata;
  logic [3:0]    a_wstrb;

  assign accept = (state == IDLE) && bus.req_valid;

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (bus.req_valid) nxt = (LAT == 0) ? RESP : WAIT;
      WAIT: if (cnt == ONE_C)  nxt = RESP;
      RESP: if (bus.resp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // With LAT==0 the access happens on the accepting edge, so it must use the
  // live request fields rather than the (not yet loaded) request registers.
  always_comb begin
    if (LAT == 0) begin
      do_acc  = accept;
      a_wen   = bus.req_wen;
      a_addr  = bus.req_addr;
      a_wdata = bus.req_wdata;
      a_wstrb = bus.req_wstrb;
    end else begin
      do_acc  = (state == WAIT) && (cnt == ONE_C);
      a_wen   = wen_q;
      a_addr  = addr_q;
      a_wdata = wdata_q;
      a_wstrb = wstrb_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        wen_q   <= bus.req_wen;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        wstrb_q <= bus.req_wstrb;
        cnt     <= LAT_C;
      end else if (state == WAIT) begin
        cnt <= cnt - ONE_C;
      end
      if (do_acc) begin
        if (a_addr[1:0] != 2'b00) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end else if (a_wen) begin
          pmem_write(int'(32'(a_addr)), int'(a_wdata), byte'(8'(a_wstrb)));
          rdata_q <= '0;
          err_q   <= 1'b0;
        end else begin
          rdata_q <= pmem_read(int'(32'(a_addr)), WORD_BYTES);
          err_q   <= 1'b0;
        end
      end
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_pmem_slave.sv
// Self-checking bench for pmem_slave: a LAT=2 and a LAT=0 instance share one
// physical memory and are checked against a word-level reference memory.
module tb_pmem_slave;
  import pmem_pkg::*;

  localparam int LAT_A = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pmem_slave_if #(.AW(32)) b2 ();
  pmem_slave_if #(.AW(32)) b0 ();

  pmem_slave #(.LAT(LAT_A), .AW(32)) u_lat2 (.clk(clk), .rst(rst), .bus(b2));
  pmem_slave #(.LAT(0),     .AW(32)) u_lat0 (.clk(clk), .rst(rst), .bus(b0));

  int checks = 0;
  int errors = 0;

  int unsigned refmem [int unsigned];

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int unsigned k;
    k = a & ~32'h3;
    return refmem.exists(k) ? refmem[k] : 32'h0;
  endfunction

  // Expected outcome of one transaction; updates the reference memory.
  function automatic void ref_txn(input bit wen, input logic [31:0] a, input logic [31:0] wd,
                                  input logic [3:0] s, output logic [31:0] rd, output logic er,
                                  output int unsigned ncalls);
    logic [31:0] w;
    if (a[1:0] != 2'b00) begin
      rd = 32'h0; er = 1'b1; ncalls = 0;
    end else if (wen) begin
      w = ref_word(a);
      for (int i = 0; i < 4; i++)
        if (s[i]) w[8*i +: 8] = wd[8*i +: 8];
      refmem[a] = w;
      rd = 32'h0; er = 1'b0; ncalls = 1;
    end else begin
      rd = ref_word(a); er = 1'b0; ncalls = 1;
    end
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pmem_write(int'(a), int'(d), 8'h0F);
    refmem[a] = d;
  endtask

  task automatic drive(input bit z, input bit v, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    if (z) begin
      b0.req_valid = v; b0.req_wen = w; b0.req_addr = a; b0.req_wdata = d; b0.req_wstrb = s;
    end else begin
      b2.req_valid = v; b2.req_wen = w; b2.req_addr = a; b2.req_wdata = d; b2.req_wstrb = s;
    end
  endtask

  task automatic set_rr(input bit z, input bit r);
    if (z) b0.resp_ready = r; else b2.resp_ready = r;
  endtask

  function automatic bit rv(input bit z);
    return z ? b0.resp_valid : b2.resp_valid;
  endfunction

  // Issues one request at cycle 0 (called just after a rising edge, slave idle)
  // with resp_ready held high; returns the cycle in which resp_valid was seen.
  task automatic run_txn(input bit z, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int lat, output logic [31:0] rd,
                         output logic er);
    lat = -1; rd = 'x; er = 1'bx;
    drive(z, 1'b1, w, a, d, s);
    set_rr(z, 1'b1);
    @(posedge clk); #1;
    drive(z, 1'b0, $urandom_range(0, 1), $urandom, $urandom, 4'($urandom));
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (rv(z)) begin
        lat = c;
        rd  = z ? b0.resp_rdata : b2.resp_rdata;
        er  = z ? b0.resp_err : b2.resp_err;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    set_rr(1'b0, 1'b0); set_rr(1'b1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int z = 0; z < 2; z++) begin
      logic rr, vv, ee; logic [31:0] dd;
      rr = z ? b0.req_ready : b2.req_ready;
      vv = z ? b0.resp_valid : b2.resp_valid;
      dd = z ? b0.resp_rdata : b2.resp_rdata;
      ee = z ? b0.resp_err : b2.resp_err;
      checks++; if (rr !== 1'b1) begin errors++; $display("FAIL reset_req_ready z=%0d got %b exp 1", z, rr); end
      checks++; if (vv !== 1'b0) begin errors++; $display("FAIL reset_resp_valid z=%0d got %b exp 0", z, vv); end
      checks++; if (dd !== 32'h0) begin errors++; $display("FAIL reset_rdata z=%0d got %h exp 0", z, dd); end
      checks++; if (ee !== 1'b0) begin errors++; $display("FAIL reset_err z=%0d got %b exp 0", z, ee); end
    end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_read;
    int lat; logic [31:0] rd, erd; logic er, eer; int unsigned c0, nc;
    preload(32'h8000_0000, 32'h0000_0413);
    c0 = pmem_calls;
    ref_txn(1'b0, 32'h8000_0000, '0, '0, erd, eer, nc);
    run_txn(1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, lat, rd, er);
    checks++; if (lat !== LAT_A + 1) begin errors++; $display("FAIL read_latency got %0d exp %0d", lat, LAT_A + 1); end
    checks++; if (rd !== erd) begin errors++; $display("FAIL read_rdata got %h exp %h", rd, erd); end
    checks++; if (er !== eer) begin errors++; $display("FAIL read_err got %b exp %b", er, eer); end
    checks++; if (pmem_calls - c0 !== nc) begin errors++; $display("FAIL read_calls got %0d exp %0d", pmem_calls - c0, nc); end
    @(negedge clk);
    checks++; if (b2.req_ready !== 1'b1) begin errors++; $display("FAIL read_ready_after got %b exp 1", b2.req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_masked_write;
    int lat; logic [31:0] rd, erd; logic er, eer; int unsigned nc;
    preload(32'h8000_0010, 32'h1122_3344);
    ref_txn(1'b1, 32'h8000_0010, 32'hAABB_CCDD, 4'b0101, erd, eer, nc);
    run_txn(1'b0, 1'b1, 32'h8000_0010, 32'hAABB_CCDD, 4'b0101, lat, rd, er);
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL mwrite_resp got %h/%b exp 0/0", rd, er); end
    run_txn(1'b0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, lat, rd, er);
    checks++; if (rd !== 32'h11BB_33DD || rd !== ref_word(32'h8000_0010)) begin
      errors++; $display("FAIL mwrite_readback got %h exp %h", rd, 32'h11BB_33DD);
    end
    // zero mask: access still made, contents unchanged
    run_txn(1'b0, 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, lat, rd, er);
    run_txn(1'b0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, lat, rd, er);
    checks++; if (rd !== 32'h11BB_33DD) begin errors++; $display("FAIL zero_mask_readback got %h exp %h", rd, 32'h11BB_33DD); end
  endtask

  task automatic test_backpressure;
    logic [31:0] e1, e2, r0; logic ee; int unsigned nc, c0; int c2; bit seen;
    preload(32'h8000_0030, $urandom);
    preload(32'h8000_0034, $urandom);
    ref_txn(1'b0, 32'h8000_0030, '0, '0, e1, ee, nc);
    ref_txn(1'b0, 32'h8000_0034, '0, '0, e2, ee, nc);
    c0 = pmem_calls;
    drive(1'b0, 1'b1, 1'b0, 32'h8000_0030, 32'h0, 4'h0);
    set_rr(1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 32'h8000_0034, 32'h0, 4'h0);
    seen = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (b2.resp_valid) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_first_resp got timeout exp resp_valid"); end
    r0 = b2.resp_rdata;
    checks++; if (r0 !== e1) begin errors++; $display("FAIL bp_rdata got %h exp %h", r0, e1); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (b2.resp_valid !== 1'b1 || b2.resp_rdata !== r0 || b2.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold k=%0d got v=%b d=%h rdy=%b exp v=1 d=%h rdy=0",
                 k, b2.resp_valid, b2.resp_rdata, b2.req_ready, r0);
      end
      @(posedge clk); @(negedge clk);
    end
    set_rr(1'b0, 1'b1);
    @(negedge clk);
    checks++; if (b2.resp_valid !== 1'b0 || b2.req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_after_handshake got v=%b rdy=%b exp v=0 rdy=1", b2.resp_valid, b2.req_ready);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    c2 = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (b2.resp_valid) begin c2 = c; break; end
    end
    checks++; if (c2 !== LAT_A + 1) begin errors++; $display("FAIL bp_second_latency got %0d exp %0d", c2, LAT_A + 1); end
    checks++; if (b2.resp_rdata !== e2) begin errors++; $display("FAIL bp_second_rdata got %h exp %h", b2.resp_rdata, e2); end
    checks++; if (pmem_calls - c0 !== 2) begin errors++; $display("FAIL bp_calls got %0d exp 2", pmem_calls - c0); end
    @(posedge clk); #1;
  endtask

  task automatic test_misaligned;
    int lat; logic [31:0] rd; logic er; int unsigned c0;
    c0 = pmem_calls;
    run_txn(1'b0, 1'b0, 32'h8000_0002, 32'h0, 4'h0, lat, rd, er);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL misaligned_read got %h/%b exp 0/1", rd, er); end
    checks++; if (pmem_calls !== c0) begin errors++; $display("FAIL misaligned_read_calls got %0d exp 0", pmem_calls - c0); end
    run_txn(1'b0, 1'b1, 32'h8000_0001, 32'hFFFF_FFFF, 4'hF, lat, rd, er);
    checks++; if (er !== 1'b1 || pmem_calls !== c0) begin
      errors++; $display("FAIL misaligned_write got err=%b calls=%0d exp err=1 calls=0", er, pmem_calls - c0);
    end
    run_txn(1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, lat, rd, er);
    checks++; if (rd !== ref_word(32'h8000_0000)) begin errors++; $display("FAIL misaligned_mem_kept got %h exp %h", rd, ref_word(32'h8000_0000)); end
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] rd; logic er; int unsigned c0;
    preload(32'h8000_0020, 32'hDEAD_BEEF);
    c0 = pmem_calls;
    drive(1'b0, 1'b1, 1'b1, 32'h8000_0020, 32'h0BAD_F00D, 4'hF);
    set_rr(1'b0, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (b2.req_ready !== 1'b1 || b2.resp_valid !== 1'b0 || b2.resp_rdata !== 32'h0 || b2.resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs got rdy=%b v=%b d=%h e=%b exp 1/0/0/0",
               b2.req_ready, b2.resp_valid, b2.resp_rdata, b2.resp_err);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (pmem_calls !== c0) begin errors++; $display("FAIL reset_mid_calls got %0d exp 0", pmem_calls - c0); end
    run_txn(1'b0, 1'b0, 32'h8000_0020, 32'h0, 4'h0, lat, rd, er);
    checks++; if (rd !== 32'hDEAD_BEEF || lat !== LAT_A + 1) begin
      errors++; $display("FAIL reset_mid_next got %h lat %0d exp DEADBEEF lat %0d", rd, lat, LAT_A + 1);
    end
  endtask

  task automatic test_lat0;
    int lat; logic [31:0] rd, e; logic er, ee; int unsigned nc;
    logic [31:0] addrs [6];
    logic [31:0] expq [$];
    int idx, last, nresp;
    preload(32'h8000_0200, 32'hCAFE_0001);
    ref_txn(1'b0, 32'h8000_0200, '0, '0, e, ee, nc);
    run_txn(1'b1, 1'b0, 32'h8000_0200, 32'h0, 4'h0, lat, rd, er);
    checks++; if (lat !== 1 || rd !== e || er !== ee) begin
      errors++; $display("FAIL lat0_read got lat=%0d d=%h e=%b exp lat=1 d=%h e=%b", lat, rd, er, e, ee);
    end
    for (int i = 0; i < 6; i++) begin
      addrs[i] = 32'h8000_0200 + 32'($urandom_range(0, 15)) * 4;
      preload(addrs[i], $urandom);
    end
    idx = 0; last = -1; nresp = 0;
    drive(1'b1, 1'b1, 1'b0, addrs[0], 32'h0, 4'h0);
    set_rr(1'b1, 1'b1);
    for (int c = 0; c < 40 && nresp < 6; c++) begin
      @(negedge clk);
      if (b0.resp_valid) begin
        e = (expq.size() > 0) ? expq.pop_front() : 32'hx;
        checks++; if (b0.resp_rdata !== e) begin errors++; $display("FAIL lat0_b2b_rdata n=%0d got %h exp %h", nresp, b0.resp_rdata, e); end
        if (last >= 0) begin
          checks++; if (c - last !== 2) begin errors++; $display("FAIL lat0_b2b_period n=%0d got %0d exp 2", nresp, c - last); end
        end
        last = c; nresp++;
      end
      if (b0.req_ready && b0.req_valid && idx < 6) begin
        expq.push_back(ref_word(addrs[idx]));
        idx++;
      end
      @(posedge clk); #1;
      if (idx < 6) drive(1'b1, 1'b1, 1'b0, addrs[idx], 32'h0, 4'h0);
      else         drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    end
    checks++; if (nresp !== 6) begin errors++; $display("FAIL lat0_b2b_count got %0d exp 6", nresp); end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    int lat; logic [31:0] rd, erd, a, d; logic er, eer; logic [3:0] s; bit z, w; int unsigned c0, nc;
    for (int n = 0; n < 24; n++) begin
      z = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = 32'h8000_0100 + 32'($urandom_range(0, 15)) * 4;
      if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
      d = $urandom;
      s = 4'($urandom);
      ref_txn(w, a, d, s, erd, eer, nc);
      c0 = pmem_calls;
      run_txn(z, w, a, d, s, lat, rd, er);
      checks++;
      if (rd !== erd || er !== eer || lat !== (z ? 1 : LAT_A + 1) || pmem_calls - c0 !== nc) begin
        errors++;
        $display("FAIL random n=%0d z=%0d w=%0d a=%h got d=%h e=%b lat=%0d calls=%0d exp d=%h e=%b lat=%0d calls=%0d",
                 n, z, w, a, rd, er, lat, pmem_calls - c0, erd, eer, z ? 1 : LAT_A + 1, nc);
      end
    end
  endtask

  initial begin
    test_reset;
    test_read;
    test_masked_write;
    test_backpressure;
    test_misaligned;
    test_reset_mid;
    test_lat0;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
